// File: rtl/axis_credit_tx_if.sv
// Bus bundle for axis_credit_tx: upstream AXI-Stream input, ready-less link output and credit return.
// master = upstream/far-end side, slave = the transmitter itself.
interface axis_credit_tx_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int USER_WIDTH = 1
);
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic [KEEP_WIDTH-1:0] s_axis_tkeep;
   logic                  s_axis_tvalid;
   logic                  s_axis_tready;
   logic                  s_axis_tlast;
   logic [USER_WIDTH-1:0] s_axis_tuser;
   logic [DATA_WIDTH-1:0] link_tdata;
   logic [KEEP_WIDTH-1:0] link_tkeep;
   logic                  link_tvalid;
   logic                  link_tlast;
   logic [USER_WIDTH-1:0] link_tuser;
   logic                  link_credit;

   modport master (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, link_credit,
      input  s_axis_tready, link_tdata, link_tkeep, link_tvalid, link_tlast, link_tuser
   );

   modport slave (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser, link_credit,
      output s_axis_tready, link_tdata, link_tkeep, link_tvalid, link_tlast, link_tuser
   );
endinterface

// File: rtl/axis_credit_tx.sv
// Credit-flow-controlled AXI-Stream transmitter: sends a beat only while holding a credit.
// Define AXIS_CREDIT_TX_STATS_EN to add stat_credit_level / stat_pkt_count outputs.
module axis_credit_tx #(
   parameter int DATA_WIDTH    = 8,
   parameter int KEEP_ENABLE   = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH    = (DATA_WIDTH + 7) / 8,
   parameter int LAST_ENABLE   = 1,
   parameter int USER_ENABLE   = 1,
   parameter int USER_WIDTH    = 1,
   parameter int LENGTH        = 2,
   parameter int CREDIT_LENGTH = 2,
   parameter int CREDITS       = 8,
   localparam int CNT_WIDTH    = $clog2(CREDITS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   axis_credit_tx_if.slave bus,
   output logic            credit_err
`ifdef AXIS_CREDIT_TX_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] stat_credit_level,
   output logic [31:0]          stat_pkt_count
`endif
);
   localparam int SW = CNT_WIDTH + 1;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   beat_t                in_beat;
   beat_t                beat_pipe [LENGTH];
   logic [LENGTH-1:0]    vld_pipe;
   logic [CNT_WIDTH-1:0] credit_cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [SW-1:0]        cnt_sum;
   logic                 tready_reg;
   logic                 take;
   logic                 ret;
   logic                 over;

   assign take              = bus.s_axis_tvalid & tready_reg;
   assign bus.s_axis_tready = tready_reg;
   assign in_beat           = {bus.s_axis_tdata, bus.s_axis_tkeep, bus.s_axis_tlast, bus.s_axis_tuser};

   // Forward path: data registers carry no reset, only the valid shift register does.
   always_ff @(posedge clk) begin
      beat_pipe[0] <= in_beat;
      for (int i = 1; i < LENGTH; i++) beat_pipe[i] <= beat_pipe[i-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= take;
         for (int i = 1; i < LENGTH; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   assign bus.link_tvalid = vld_pipe[LENGTH-1];
   assign bus.link_tdata  = beat_pipe[LENGTH-1].data;
   assign bus.link_tkeep  = (KEEP_ENABLE != 0) ? beat_pipe[LENGTH-1].keep : '1;
   assign bus.link_tlast  = (LAST_ENABLE != 0) ? beat_pipe[LENGTH-1].last : 1'b1;
   assign bus.link_tuser  = (USER_ENABLE != 0) ? beat_pipe[LENGTH-1].user : '0;

   generate
      if (CREDIT_LENGTH == 0) begin : g_no_cpipe
         assign ret = bus.link_credit;
      end else begin : g_cpipe
         logic [CREDIT_LENGTH-1:0] cred_pipe;
         always_ff @(posedge clk) begin
            if (rst) begin
               cred_pipe <= '0;
            end else begin
               cred_pipe[0] <= bus.link_credit;
               for (int i = 1; i < CREDIT_LENGTH; i++) cred_pipe[i] <= cred_pipe[i-1];
            end
         end
         assign ret = cred_pipe[CREDIT_LENGTH-1];
      end
   endgenerate

   // One extra bit so a surplus credit at full count is visible before clamping.
   always_comb begin
      cnt_sum  = {1'b0, credit_cnt} - SW'(take) + SW'(ret);
      over     = (cnt_sum > SW'(CREDITS));
      cnt_next = over ? CNT_WIDTH'(CREDITS) : cnt_sum[CNT_WIDTH-1:0];
   end

   // Ready is registered from the next count: no comb path from link_credit or tvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_cnt <= CNT_WIDTH'(CREDITS);
         tready_reg <= 1'b0;
         credit_err <= 1'b0;
      end else begin
         credit_cnt <= cnt_next;
         tready_reg <= (cnt_next != '0);
         credit_err <= credit_err | over;
      end
   end

`ifdef AXIS_CREDIT_TX_STATS_EN
   assign stat_credit_level = credit_cnt;

   always_ff @(posedge clk) begin
      if (rst) stat_pkt_count <= '0;
      else if (take && bus.s_axis_tlast) stat_pkt_count <= stat_pkt_count + 32'd1;
   end
`endif
endmodule

// File: tb/tb_axis_credit_tx.sv
// Directed bench for axis_credit_tx: cycle table for fill/exhaust/credit return, then
// hand sequences for take+ret, surplus credit, mid-burst reset and disabled side-band fields.
module tb_axis_credit_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axis_credit_tx_if #(.DATA_WIDTH(16), .KEEP_WIDTH(2), .USER_WIDTH(1)) a_if ();
   axis_credit_tx_if #(.DATA_WIDTH(8),  .KEEP_WIDTH(1), .USER_WIDTH(1)) b_if ();
   logic a_err, b_err;
`ifdef AXIS_CREDIT_TX_STATS_EN
   logic [3:0]  a_lvl, b_lvl;
   logic [31:0] a_pkts, b_pkts;
`endif

   axis_credit_tx #(
      .DATA_WIDTH(16), .LENGTH(2), .CREDIT_LENGTH(2), .CREDITS(8)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(a_if), .credit_err(a_err)
`ifdef AXIS_CREDIT_TX_STATS_EN
      , .stat_credit_level(a_lvl), .stat_pkt_count(a_pkts)
`endif
   );

   axis_credit_tx #(
      .DATA_WIDTH(8), .KEEP_ENABLE(0), .LAST_ENABLE(0), .USER_ENABLE(0),
      .LENGTH(2), .CREDIT_LENGTH(2), .CREDITS(8)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(b_if), .credit_err(b_err)
`ifdef AXIS_CREDIT_TX_STATS_EN
      , .stat_credit_level(b_lvl), .stat_pkt_count(b_pkts)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;

   // Row: inputs applied before a clock edge, expected outputs just after that edge.
   typedef struct {
      logic       rst;
      logic       vld;
      logic       cred;
      logic [7:0] idx;
      logic       e_rdy;
      logic       e_lv;
      logic [7:0] e_idx;
      logic       e_err;
   } vec_t;
   vec_t tbl [19];

   // Beat encoding: every side-band field derived from the beat index.
   function automatic logic [15:0] dat_of(input logic [7:0] i);
      return {8'h5A, i};
   endfunction
   function automatic logic [1:0] keep_of(input logic [7:0] i);
      return i[1:0] ^ 2'b10;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic vld, input logic [7:0] idx, input logic cred);
      a_if.s_axis_tvalid = vld;
      a_if.s_axis_tdata  = dat_of(idx);
      a_if.s_axis_tkeep  = keep_of(idx);
      a_if.s_axis_tlast  = idx[0];
      a_if.s_axis_tuser  = idx[1];
      a_if.link_credit   = cred;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Holds tvalid and counts accepts until ready drops (bounded).
   task automatic drain(input string name, input int exp_n);
      int n;
      n = 0;
      a_if.s_axis_tvalid = 1'b1;
      while (a_if.s_axis_tready && n < 20) begin
         tick();
         n++;
      end
      a_if.s_axis_tvalid = 1'b0;
      chk(name, n, exp_n);
   endtask

   initial begin
      drive_a(1'b0, 8'd0, 1'b0);
      b_if.s_axis_tvalid = 1'b0;
      b_if.s_axis_tdata  = 8'h00;
      b_if.s_axis_tkeep  = 1'b1;
      b_if.s_axis_tlast  = 1'b1;
      b_if.s_axis_tuser  = 1'b0;
      b_if.link_credit   = 1'b0;

      //          rst vld cred idx   rdy lv  eidx err
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 8'd0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1, 8'd1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd3, 1'b1, 1'b1, 8'd2, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 1'b1, 8'd3, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'd5, 1'b1, 1'b1, 8'd4, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'd6, 1'b1, 1'b1, 8'd5, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'd7, 1'b0, 1'b1, 8'd6, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b1, 8'd7, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 8'd8, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[14] = '{1'b0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 1'b0, 8'd0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b0, 8'd0, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1, 8'd8, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 8'd0, 1'b0};

      // Fill, exhaust, single credit return with CREDIT_LENGTH=2
      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst;
         drive_a(tbl[i].vld, tbl[i].idx, tbl[i].cred);
         tick();
         chk($sformatf("row%0d tready", i), a_if.s_axis_tready, tbl[i].e_rdy);
         chk($sformatf("row%0d link_tvalid", i), a_if.link_tvalid, tbl[i].e_lv);
         chk($sformatf("row%0d credit_err", i), a_err, tbl[i].e_err);
         if (tbl[i].e_lv) begin
            chk($sformatf("row%0d link_tdata", i), a_if.link_tdata, dat_of(tbl[i].e_idx));
            chk($sformatf("row%0d link_tkeep", i), a_if.link_tkeep, keep_of(tbl[i].e_idx));
            chk($sformatf("row%0d link_tlast", i), a_if.link_tlast, tbl[i].e_idx[0]);
            chk($sformatf("row%0d link_tuser", i), a_if.link_tuser, tbl[i].e_idx[1]);
         end
      end

      // take and ret in the same cycle at count 3
      drive_a(1'b0, 8'd1, 1'b0);
      reset_pulse();
      a_if.s_axis_tvalid = 1'b1;
      repeat (5) tick();
      a_if.s_axis_tvalid = 1'b0;
      a_if.link_credit   = 1'b1;
      tick();
      a_if.link_credit   = 1'b0;
      tick();
      a_if.s_axis_tvalid = 1'b1;
      tick();
      chk("take+ret tready", a_if.s_axis_tready, 1'b1);
      chk("take+ret credit_err", a_err, 1'b0);
`ifdef AXIS_CREDIT_TX_STATS_EN
      chk("take+ret level", a_lvl, 4'd3);
      chk("take+ret pkt_count", a_pkts, 32'd6);
`endif
      drain("take+ret remaining credits", 3);

      // Surplus credit at full count
      drive_a(1'b0, 8'd0, 1'b0);
      reset_pulse();
      a_if.link_credit = 1'b1;
      tick();
      a_if.link_credit = 1'b0;
      tick();
      chk("surplus err early", a_err, 1'b0);
      tick();
      chk("surplus err set", a_err, 1'b1);
      repeat (3) tick();
      chk("surplus err sticky", a_err, 1'b1);
`ifdef AXIS_CREDIT_TX_STATS_EN
      chk("surplus level", a_lvl, 4'd8);
`endif
      drain("surplus count stays 8", 8);
      chk("surplus err after drain", a_err, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst clears err", a_err, 1'b0);
      rst = 1'b0;
      tick();

      // Reset mid-burst: in-flight beats discarded, count restored
      reset_pulse();
      a_if.s_axis_tvalid = 1'b1;
      repeat (6) tick();
      chk("midburst link busy", a_if.link_tvalid, 1'b1);
      rst = 1'b1;
      tick();
      chk("midrst link_tvalid", a_if.link_tvalid, 1'b0);
      chk("midrst tready", a_if.s_axis_tready, 1'b0);
      rst = 1'b0;
      a_if.s_axis_tvalid = 1'b0;
      tick();
      chk("postrst tready", a_if.s_axis_tready, 1'b1);
      chk("postrst link_tvalid", a_if.link_tvalid, 1'b0);
      tick();
      chk("postrst no stale beat", a_if.link_tvalid, 1'b0);
`ifdef AXIS_CREDIT_TX_STATS_EN
      chk("postrst level", a_lvl, 4'd8);
`endif
      drain("postrst credits", 8);

      // Disabled keep/last/user: outputs tied off
      b_if.s_axis_tdata  = 8'h3C;
      b_if.s_axis_tkeep  = 1'b0;
      b_if.s_axis_tlast  = 1'b0;
      b_if.s_axis_tuser  = 1'b1;
      b_if.s_axis_tvalid = 1'b1;
      tick();
      b_if.s_axis_tvalid = 1'b0;
      chk("tie link_tvalid early", b_if.link_tvalid, 1'b0);
      tick();
      chk("tie link_tvalid", b_if.link_tvalid, 1'b1);
      chk("tie link_tdata", b_if.link_tdata, 8'h3C);
      chk("tie link_tkeep", b_if.link_tkeep, 1'b1);
      chk("tie link_tlast", b_if.link_tlast, 1'b1);
      chk("tie link_tuser", b_if.link_tuser, 1'b0);
      chk("tie credit_err", b_err, 1'b0);
`ifdef AXIS_CREDIT_TX_STATS_EN
      chk("tie pkt_count", b_pkts, 32'd0);
      chk("tie level", b_lvl, 4'd7);
`endif
      tick();
      chk("tie link_tvalid drop", b_if.link_tvalid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
